// File: rtl/bf16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bf16_pkg
// Description : Shared bfloat16 field widths, constants and unpacked-operand
//               type used across the FMA datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package bf16_pkg;

  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 7;
  localparam int SIG_W    = FRAC_W + 1;
  localparam int ALIGN_W  = SIG_W + 3;
  localparam int EXP_BIAS = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } bf16_unpk_t;

  // Exponent 0 is zero: no denormals, so the fraction is discarded.
  function automatic bf16_unpk_t bf16_unpack(input logic [15:0] x);
    bf16_unpk_t u;
    u.sign = x[15];
    u.exp  = x[14:7];
    u.sig  = (x[14:7] == '0) ? '0 : {1'b1, x[6:0]};
    return u;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bf16_lzc.sv
`default_nettype none
// ============================================================================
// Module      : bf16_lzc
// Description : Leading-zero count of an 11-bit significand; all-zero -> 11.
// Revision    : 1.0 - initial release
// ============================================================================
module bf16_lzc
  import bf16_pkg::*;
(
  input  logic [ALIGN_W-1:0] i_data,
  output logic [3:0]         o_count
);

  logic w_found;

  always_comb begin
    o_count = 4'(ALIGN_W);
    w_found = 1'b0;
    for (int i = ALIGN_W - 1; i >= 0; i--) begin
      if (!w_found && i_data[i]) begin
        o_count = 4'(ALIGN_W - 1 - i);
        w_found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bfloat16_add_stage.sv
`default_nettype none
// ============================================================================
// Module      : bfloat16_add_stage
// Description : 3-stage bfloat16 adder closing A*B+C (align, add, normalize).
//               Define BF16_ROUND_RNE_EN for round-to-nearest-even; default
//               build truncates.
// Revision    : 1.0 - initial release
// ============================================================================
module bfloat16_add_stage
  import bf16_pkg::*;
#(
  parameter int PIPE_DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] prod,
  input  logic        prod_ov,
  input  logic [15:0] addend,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] sum,
  output logic        ov
);

`ifdef BF16_ROUND_RNE_EN
  localparam logic c_rne_en = 1'b1;
`else
  localparam logic c_rne_en = 1'b0;
`endif

  logic                  w_advance;
  logic [PIPE_DEPTH-1:0] r_valid;

  // Global stall: every stage moves together or not at all.
  assign w_advance = out_ready | ~out_valid;
  assign in_ready  = w_advance;
  assign out_valid = r_valid[PIPE_DEPTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (w_advance) begin
      r_valid <= {r_valid[PIPE_DEPTH-2:0], in_valid};
    end
  end

  // ---------------- S1: unpack / align ----------------
  bf16_unpk_t         w_p, w_c, w_big, w_small;
  logic               w_p_big;
  logic               w_in_ovf;
  logic [EXP_W-1:0]   w_diff;
  logic [ALIGN_W-1:0] w_small_ext, w_shifted, w_lost, w_aligned;

  assign w_p         = bf16_unpack(prod);
  assign w_c         = bf16_unpack(addend);
  assign w_p_big     = {w_p.exp, w_p.sig} >= {w_c.exp, w_c.sig};
  assign w_big       = w_p_big ? w_p : w_c;
  assign w_small     = w_p_big ? w_c : w_p;
  assign w_diff      = w_big.exp - w_small.exp;
  assign w_small_ext = {w_small.sig, 3'b000};
  assign w_shifted   = w_small_ext >> w_diff;
  assign w_lost      = w_small_ext & ((ALIGN_W'(1) << w_diff) - ALIGN_W'(1));
  assign w_aligned   = (w_diff >= 8'(ALIGN_W))
                     ? {{(ALIGN_W-1){1'b0}}, |w_small.sig}
                     : {w_shifted[ALIGN_W-1:1], w_shifted[0] | (|w_lost)};
  assign w_in_ovf    = prod_ov | (w_p.exp == EXP_MAX) | (w_c.exp == EXP_MAX);

  logic               r1_ovf, r1_sign, r1_sub;
  logic [EXP_W-1:0]   r1_exp;
  logic [ALIGN_W-1:0] r1_a, r1_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_ovf  <= 1'b0;
      r1_sign <= 1'b0;
      r1_sub  <= 1'b0;
      r1_exp  <= '0;
      r1_a    <= '0;
      r1_b    <= '0;
    end else if (w_advance) begin
      r1_ovf  <= w_in_ovf;
      r1_sign <= w_big.sign;
      r1_sub  <= w_big.sign ^ w_small.sign;
      r1_exp  <= w_big.exp;
      r1_a    <= {w_big.sig, 3'b000};
      r1_b    <= w_aligned;
    end
  end

  // ---------------- S2: add / subtract ----------------
  // r1_a is the larger magnitude, so the subtraction never goes negative.
  logic [ALIGN_W:0] w_mag;

  assign w_mag = r1_sub ? ({1'b0, r1_a} - {1'b0, r1_b})
                        : ({1'b0, r1_a} + {1'b0, r1_b});

  logic               r2_ovf, r2_sign;
  logic [EXP_W-1:0]   r2_exp;
  logic [ALIGN_W:0]   r2_mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_ovf  <= 1'b0;
      r2_sign <= 1'b0;
      r2_exp  <= '0;
      r2_mag  <= '0;
    end else if (w_advance) begin
      r2_ovf  <= r1_ovf;
      r2_sign <= r1_sign;
      r2_exp  <= r1_exp;
      r2_mag  <= w_mag;
    end
  end

  // ---------------- S3: normalize / round / pack ----------------
  logic [3:0]          w_lz;
  logic [ALIGN_W-1:0]  w_norm;
  logic signed [9:0]   w_exp_n, w_exp_f;
  logic                w_round_up;
  logic [SIG_W:0]      w_sig_r;
  logic [FRAC_W-1:0]   w_frac;
  logic [15:0]         w_sum;
  logic                w_ov;

  bf16_lzc u_lzc (
    .i_data  (r2_mag[ALIGN_W-1:0]),
    .o_count (w_lz)
  );

  always_comb begin
    w_norm  = '0;
    w_exp_n = '0;
    if (r2_mag[ALIGN_W]) begin
      w_norm  = {r2_mag[ALIGN_W:2], r2_mag[1] | r2_mag[0]};
      w_exp_n = $signed({2'b00, r2_exp}) + 10'sd1;
    end else begin
      w_norm  = r2_mag[ALIGN_W-1:0] << w_lz;
      w_exp_n = $signed({2'b00, r2_exp}) - $signed({6'b000000, w_lz});
    end
  end

  // Bits [2:0] of w_norm are guard, round, sticky; bit 3 is the result LSB.
  assign w_round_up = c_rne_en & w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
  assign w_sig_r    = {1'b0, w_norm[ALIGN_W-1:3]} + 9'(w_round_up);
  assign w_exp_f    = w_exp_n + $signed({9'b0, w_sig_r[SIG_W]});
  assign w_frac     = w_sig_r[SIG_W] ? w_sig_r[SIG_W-1:1] : w_sig_r[FRAC_W-1:0];

  always_comb begin
    w_sum = '0;
    w_ov  = 1'b0;
    if (r2_ovf) begin
      w_ov = 1'b1;
    end else if (r2_mag != '0) begin
      if (w_exp_f <= 10'sd0 || w_exp_f >= 10'sd255) begin
        w_ov = 1'b1;
      end else begin
        w_sum = {r2_sign, w_exp_f[EXP_W-1:0], w_frac};
      end
    end
  end

  logic [15:0] r_sum;
  logic        r_ov;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_ov  <= 1'b0;
    end else if (w_advance) begin
      r_sum <= w_sum;
      r_ov  <= w_ov;
    end
  end

  assign sum = r_sum;
  assign ov  = r_ov;

endmodule
`default_nettype wire

// File: tb/tb_bfloat16_add_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_bfloat16_add_stage
// Description : Directed self-checking bench for bfloat16_add_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bfloat16_add_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] prod;
  logic        prod_ov;
  logic [15:0] addend;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        ov;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] st_add [5] = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080, 16'h40A0};
  logic [15:0] st_exp [5] = '{16'h4000, 16'h4040, 16'h4080, 16'h40A0, 16'h40C0};

  bfloat16_add_stage #(.PIPE_DEPTH(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prod      (prod),
    .prod_ov   (prod_ov),
    .addend    (addend),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .ov        (ov)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one operation with out_ready=1 and check the 3-cycle latency.
  task automatic run_one(input string tag, input logic [15:0] p, input logic pov,
                         input logic [15:0] c, input logic [15:0] es, input logic eov);
    @(negedge clk);
    out_ready = 1'b1;
    prod      = p;
    prod_ov   = pov;
    addend    = c;
    in_valid  = 1'b1;
    #1 check_eq({tag, "_inrdy"}, {15'b0, in_ready}, 16'd1);
    @(negedge clk);
    in_valid = 1'b0;
    prod_ov  = 1'b0;
    check_eq({tag, "_lat1"}, {15'b0, out_valid}, 16'd0);
    @(negedge clk);
    check_eq({tag, "_lat2"}, {15'b0, out_valid}, 16'd0);
    @(negedge clk);
    check_eq({tag, "_vld"}, {15'b0, out_valid}, 16'd1);
    check_eq({tag, "_sum"}, sum, es);
    check_eq({tag, "_ov"}, {15'b0, ov}, {15'b0, eov});
  endtask

  initial begin
    int  n_sent;
    int  n_recv;
    bit  saw_stall;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    prod      = '0;
    prod_ov   = 1'b0;
    addend    = '0;
    out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check_eq("rst_vld", {15'b0, out_valid}, 16'd0);
    check_eq("rst_sum", sum, 16'h0000);
    check_eq("rst_ov", {15'b0, ov}, 16'd0);
    check_eq("rst_inrdy", {15'b0, in_ready}, 16'd1);
    rst_n = 1'b1;
    #1 check_eq("post_rst_inrdy", {15'b0, in_ready}, 16'd1);

    run_one("one_plus_one", 16'h3F80, 1'b0, 16'h3F80, 16'h4000, 1'b0);
    run_one("cancel",       16'h3F80, 1'b0, 16'hBF80, 16'h0000, 1'b0);
    run_one("prod_ov",      16'h3F80, 1'b1, 16'h3F80, 16'h0000, 1'b1);
    run_one("exp_ovf",      16'h7F7F, 1'b0, 16'h7F7F, 16'h0000, 1'b1);
`ifdef BF16_ROUND_RNE_EN
    run_one("round",        16'h3F80, 1'b0, 16'h3BC0, 16'h3F81, 1'b0);
`else
    run_one("round",        16'h3F80, 1'b0, 16'h3BC0, 16'h3F80, 1'b0);
`endif
    run_one("zero_prod",    16'h0000, 1'b0, 16'h4049, 16'h4049, 1'b0);
    run_one("zero_add",     16'hC0A0, 1'b0, 16'h0000, 16'hC0A0, 1'b0);
    run_one("denorm_zero",  16'h0055, 1'b0, 16'h3F80, 16'h3F80, 1'b0);
    run_one("inf_addend",   16'h3F80, 1'b0, 16'h7F80, 16'h0000, 1'b1);
    run_one("sub_norm",     16'h4000, 1'b0, 16'hBF80, 16'h3F80, 1'b0);
    run_one("big_sign",     16'h3F80, 1'b0, 16'hC040, 16'hC000, 1'b0);
    run_one("far_shift",    16'h4780, 1'b0, 16'h3F80, 16'h4780, 1'b0);
    run_one("underflow",    16'h0081, 1'b0, 16'h8080, 16'h0000, 1'b1);

    // Back-to-back inputs against a 6-cycle downstream stall.
    n_sent    = 0;
    n_recv    = 0;
    saw_stall = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 6);
      #1;
      if (out_valid) begin
        if (n_recv >= 5) begin
          check_eq("stall_extra", {15'b0, out_valid}, 16'd0);
        end else if (out_ready) begin
          check_eq($sformatf("stall_res%0d", n_recv), sum, st_exp[n_recv]);
          check_eq($sformatf("stall_ov%0d", n_recv), {15'b0, ov}, 16'd0);
          n_recv++;
        end else begin
          check_eq("stall_inrdy", {15'b0, in_ready}, 16'd0);
          check_eq("stall_hold", sum, st_exp[n_recv]);
          if (!saw_stall) begin
            check_eq("stall_accepted", 16'(n_sent), 16'd3);
            saw_stall = 1'b1;
          end
        end
      end
      if (n_sent < 5) begin
        in_valid = 1'b1;
        prod     = 16'h3F80;
        prod_ov  = 1'b0;
        addend   = st_add[n_sent];
        if (in_ready) n_sent++;
      end else begin
        in_valid = 1'b0;
      end
    end
    check_eq("stall_count", 16'(n_recv), 16'd5);
    check_eq("stall_seen", {15'b0, saw_stall}, 16'd1);

    // Reset with three operations in flight; none may be emitted.
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      prod     = 16'h3F80;
      addend   = st_add[k];
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_eq("rst_full", {15'b0, out_valid}, 16'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_vld", {15'b0, out_valid}, 16'd0);
    check_eq("mid_rst_sum", sum, 16'h0000);
    check_eq("mid_rst_ov", {15'b0, ov}, 16'd0);
    check_eq("mid_rst_inrdy", {15'b0, in_ready}, 16'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("rst_noemit", {15'b0, out_valid}, 16'd0);
    end
    run_one("after_rst", 16'h3F80, 1'b0, 16'h4000, 16'h4040, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bfloat16_add_stage.md
BFLOAT16_ADD_STAGE -- requirements
Module: bfloat16_add_stage

Interface
REQ-001 SHALL have parameter PIPE_DEPTH, default 3, fixed pipeline depth; only the value 3 is legal.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  prod/prod_ov/addend valid this cycle.
REQ-005 SHALL have port in_ready  output  1  stage accepts input this cycle.
REQ-006 SHALL have port prod  input  16  bfloat16 product from the upstream multiplier.
REQ-007 SHALL have port prod_ov  input  1  upstream exponent over/underflow flag for prod.
REQ-008 SHALL have port addend  input  16  bfloat16 addend C of A*B+C.
REQ-009 SHALL have port out_valid  output  1  sum/ov valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts sum.
REQ-011 SHALL have port sum  output  16  bfloat16 result {sign, exp[7:0], frac[6:0]}.
REQ-012 SHALL have port ov  output  1  result over/underflow flag.

Function
REQ-013 SHALL use a 3-stage pipeline: S1 unpack/align, S2 add/subtract, S3 normalize/round/pack; each stage holds a valid bit.
REQ-014 SHALL define advance = out_ready | ~out_valid, and SHALL tie in_ready = advance.
REQ-015 SHALL move every stage one step per cycle when advance=1, and SHALL hold all stages unchanged when advance=0 (global stall, no bubble collapse).
REQ-016 SHALL capture an input only on in_valid & in_ready; latency is exactly 3 cycles from acceptance to out_valid with no stall.
REQ-017 SHALL hold sum, ov and out_valid stable while out_valid=1 and out_ready=0.
REQ-018 SHALL treat exponent 0 as zero: no denormals, fraction ignored.
REQ-019 SHALL treat exponent 8'hFF on either operand, or prod_ov=1, as overflow: result sum=16'h0000, ov=1.
REQ-020 SHALL form 8-bit significands with a hidden 1 for nonzero exponents.
REQ-021 SHALL right-shift the smaller-exponent significand by the exponent difference, keeping guard, round and sticky bits (11-bit datapath).
REQ-022 SHALL reduce a shift of 11 or more to sticky only.
REQ-023 SHALL add magnitudes when signs are equal; otherwise it SHALL subtract smaller from larger magnitude and take the larger operand's sign.
REQ-024 SHALL return sum=16'h0000, ov=0 on exact cancellation.
REQ-025 SHALL normalize a carry-out by shifting right 1 and incrementing the exponent.
REQ-026 SHALL normalize leading zeros by shifting left and decrementing the exponent per zero.
REQ-027 SHALL produce sum=16'h0000, ov=1 when the final exponent is 0 or below (underflow) or 255 or above (overflow), matching the upstream zero-on-flag convention.
REQ-028 SHALL pass a zero operand through so that the other operand is returned unchanged, with ov=0.

Reset
REQ-029 SHALL clear all stage valid bits on rst_n=0, giving out_valid=0, sum=16'h0000 and ov=0, regardless of in-flight data.
REQ-030 SHALL assert in_ready=1 during and immediately after reset, and SHALL lose in-flight operations on mid-operation reset without emitting them.

Configuration
REQ-031 SHALL, when BF16_ROUND_RNE_EN is defined, round round-to-nearest-even on guard/round/sticky.
REQ-032 SHALL re-normalize a rounding carry-out, with overflow handled per REQ-027.
REQ-033 SHALL truncate (drop guard/round/sticky) when BF16_ROUND_RNE_EN is undefined, matching the multiplier's truncation.

Structure
REQ-034 SHALL take from the shared package bf16_pkg: field widths (EXP_W=8, FRAC_W=7), EXP_BIAS=127, EXP_MAX=8'hFF, and an unpacked-operand struct typedef {sign, exp, sig}.
REQ-035 SHALL implement leading-zero count in one sub-module, bf16_lzc (11-bit input, 4-bit count), instantiated in S3.

Verification
REQ-036 SHALL verify: prod=16'h3F80, addend=16'h3F80, out_ready=1 -> sum=16'h4000, ov=0, out_valid exactly 3 cycles after acceptance.
REQ-037 SHALL verify: prod=16'h3F80, addend=16'hBF80 -> sum=16'h0000, ov=0; prod_ov=1 with any operands -> sum=16'h0000, ov=1.
REQ-038 SHALL verify: prod=16'h7F7F, addend=16'h7F7F -> sum=16'h0000, ov=1.
REQ-039 SHALL verify: prod=16'h3F80, addend=16'h3BC0 -> sum=16'h3F81 with BF16_ROUND_RNE_EN, and 16'h3F80 without it.
REQ-040 SHALL verify: 5 back-to-back inputs with out_ready=0 for 6 cycles -> in_ready=0 once out_valid=1 after 3 accepted, output held stable, all 5 results emitted in order after release with none lost or duplicated.
REQ-041 SHALL verify: rst_n pulsed low with 3 operations in flight -> out_valid=0 next cycle, none of the 3 emitted, a new input after reset gives a correct result 3 cycles later.
